// File: rtl/space_invaders_pkg.sv
// rtl/space_invaders_pkg.sv - shared types and screen/bullet constants for the game blocks
package space_invaders_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        FLYING   = 2'd2,
        COOLDOWN = 2'd3
    } bullet_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    localparam int DEF_SPEED           = 4;
    localparam int DEF_START_Y         = 440;
    localparam int DEF_TOP_Y           = 0;
    localparam int DEF_X_OFS           = 8;
    localparam int DEF_COOLDOWN_FRAMES = 8;

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - vsync synchroniser with registered rising-edge pulse
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    // sync[1:0] is the metastability pair; sync[2] is the edge-detect history
    logic [2:0] sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync       <= 3'b000;
            frame_tick <= 1'b0;
        end else begin
            sync       <= {sync[1:0], frame_clk};
            frame_tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/player_bullet_ctrl.sv
// rtl/player_bullet_ctrl.sv - single player bullet: launch, per-frame rise, hit/miss retire, cooldown
module player_bullet_ctrl
    import space_invaders_pkg::*;
#(
    parameter int SPEED           = DEF_SPEED,
    parameter int START_Y         = DEF_START_Y,
    parameter int TOP_Y           = DEF_TOP_Y,
    parameter int X_OFS           = DEF_X_OFS,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic               game_active,
    input  logic               fire,
    input  logic [COORD_W-1:0] playerX,
    input  logic               hit,
    output logic               bullet_in,
    output logic [COORD_W-1:0] bulletX,
    output logic [COORD_W-1:0] bulletY,
    output logic               score_pulse
);

    localparam int CNT_W = 8;
    localparam logic [COORD_W-1:0] RETIRE_Y  = COORD_W'(TOP_Y + SPEED);
    localparam logic [COORD_W-1:0] STEP      = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] LAUNCH_Y  = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] LAUNCH_DX = COORD_W'(X_OFS);
    localparam logic [CNT_W-1:0]   CD_LOAD   = CNT_W'(COOLDOWN_FRAMES);

    logic frame_tick;

    frame_tick_sync u_frame_tick_sync (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .frame_tick(frame_tick)
    );

    bullet_state_t      state, state_n;
    logic               bullet_in_n, score_pulse_n;
    logic [COORD_W-1:0] bulletX_n, bulletY_n;
    logic               hit_latched, hit_latched_n;
    logic [CNT_W-1:0]   cd_cnt, cd_cnt_n;
    logic               fire_d;
    logic               fire_edge;

    assign fire_edge = fire & ~fire_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            bullet_in   <= 1'b0;
            bulletX     <= '0;
            bulletY     <= '0;
            score_pulse <= 1'b0;
            hit_latched <= 1'b0;
            cd_cnt      <= '0;
            fire_d      <= 1'b0;
        end else begin
            state       <= state_n;
            bullet_in   <= bullet_in_n;
            bulletX     <= bulletX_n;
            bulletY     <= bulletY_n;
            score_pulse <= score_pulse_n;
            hit_latched <= hit_latched_n;
            cd_cnt      <= cd_cnt_n;
            fire_d      <= fire;
        end
    end

    always_comb begin
        state_n       = state;
        bullet_in_n   = bullet_in;
        bulletX_n     = bulletX;
        bulletY_n     = bulletY;
        score_pulse_n = 1'b0;
        hit_latched_n = hit_latched;
        cd_cnt_n      = cd_cnt;

        if (!game_active) begin
            state_n       = IDLE;
            bullet_in_n   = 1'b0;
            hit_latched_n = 1'b0;
            cd_cnt_n      = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bullet_in_n = 1'b0;
                    if (fire_edge) begin
                        state_n = PENDING;
                    end
                end
                PENDING: begin
                    bullet_in_n = 1'b0;
                    if (frame_tick) begin
                        bulletX_n   = playerX + LAUNCH_DX;
                        bulletY_n   = LAUNCH_Y;
                        bullet_in_n = 1'b1;
                        state_n     = FLYING;
                    end
                end
                FLYING: begin
                    // a hit seen on the tick cycle belongs to the frame that starts now
                    hit_latched_n = hit_latched | hit;
                    if (frame_tick) begin
                        if (hit_latched || (bulletY < RETIRE_Y)) begin
                            bullet_in_n   = 1'b0;
                            score_pulse_n = hit_latched;
                            hit_latched_n = 1'b0;
                            cd_cnt_n      = CD_LOAD;
                            state_n       = COOLDOWN;
                        end else begin
                            bulletY_n = bulletY - STEP;
                        end
                    end
                end
                COOLDOWN: begin
                    bullet_in_n = 1'b0;
                    if (frame_tick) begin
                        if (cd_cnt <= CNT_W'(1)) begin
                            cd_cnt_n = '0;
                            state_n  = IDLE;
                        end else begin
                            cd_cnt_n = cd_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n     = IDLE;
                    bullet_in_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// tb/tb_player_bullet_ctrl.sv - scoreboard bench for player_bullet_ctrl
module tb_player_bullet_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       game_active = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] playerX = '0;
    logic       hit = 1'b0;
    logic       bullet_in;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       score_pulse;

    player_bullet_ctrl dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .game_active(game_active),
        .fire       (fire),
        .playerX    (playerX),
        .hit        (hit),
        .bullet_in  (bullet_in),
        .bulletX    (bulletX),
        .bulletY    (bulletY),
        .score_pulse(score_pulse)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       bi;
        logic [9:0] x;
        logic [9:0] y;
        logic       sp;
        int         dt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input logic bi, input int x, input int y, input logic sp, input int dt);
        exp_t e;
        e.bi = bi; e.x = 10'(x); e.y = 10'(y); e.sp = sp; e.dt = dt;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        cyc(5);
        frame_clk = 1'b0;
        cyc(5);
    endtask

    task automatic press();
        fire = 1'b1;
        cyc(1);
        fire = 1'b0;
        cyc(2);
    endtask

    // monitor: every change of the output bundle must match the next expected event
    initial begin : monitor
        logic       p_bi, p_sp;
        logic [9:0] p_x, p_y;
        int         cycle, last_evt;
        exp_t       e;
        p_bi = 1'b0; p_sp = 1'b0; p_x = '0; p_y = '0;
        cycle = 0; last_evt = 0;
        forever begin
            @(negedge Clk);
            cycle++;
            if (bullet_in !== p_bi || bulletX !== p_x || bulletY !== p_y || score_pulse !== p_sp) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got bi=%0b x=%0d y=%0d sp=%0b, expected no change",
                             bullet_in, bulletX, bulletY, score_pulse);
                end else begin
                    e = exp_q.pop_front();
                    if (bullet_in !== e.bi || bulletX !== e.x || bulletY !== e.y || score_pulse !== e.sp ||
                        (e.dt > 0 && (cycle - last_evt) != e.dt)) begin
                        n_fail++;
                        $display("FAIL output_event: got bi=%0b x=%0d y=%0d sp=%0b dt=%0d, expected bi=%0b x=%0d y=%0d sp=%0b dt=%0d",
                                 bullet_in, bulletX, bulletY, score_pulse, cycle - last_evt,
                                 e.bi, e.x, e.y, e.sp, e.dt);
                    end
                end
                last_evt = cycle;
            end
            p_bi = bullet_in; p_x = bulletX; p_y = bulletY; p_sp = score_pulse;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int y;
        cyc(3);
        check("reset_bullet_in", int'(bullet_in), 0);
        check("reset_bulletX", int'(bulletX), 0);
        check("reset_bulletY", int'(bulletY), 0);
        check("reset_score", int'(score_pulse), 0);
        Reset_n = 1'b1;
        game_active = 1'b1;
        playerX = 10'd100;
        cyc(2);

        // launch and climb; X frozen after launch
        press();
        push(1, 108, 440, 0, -1);
        tick();
        playerX = 10'd200;
        y = 440;
        for (int k = 0; k < 10; k++) begin
            y -= 4;
            push(1, 108, y, 0, -1);
            tick();
        end

        // hit mid-frame, retire on next tick with one-cycle score
        hit = 1'b1;
        cyc(3);
        hit = 1'b0;
        cyc(2);
        push(0, 108, 400, 1, -1);
        push(0, 108, 400, 0, 1);
        tick();

        // presses before cooldown ticks 1..8 are discarded; press after tick 8 launches
        for (int k = 0; k < 8; k++) begin
            press();
            tick();
        end
        press();
        push(1, 208, 440, 0, -1);
        tick();

        // climb to the top, then miss without score
        y = 440;
        for (int k = 0; k < 110; k++) begin
            y -= 4;
            push(1, 208, y, 0, -1);
            tick();
        end
        push(0, 208, 0, 0, -1);
        fire = 1'b1;
        tick();

        // held fire through the whole cooldown and beyond must not launch
        repeat (10) tick();
        fire = 1'b0;
        cyc(2);
        playerX = 10'd300;
        press();
        push(1, 308, 440, 0, -1);
        tick();

        // asynchronous reset mid-flight at Y=300
        y = 440;
        for (int k = 0; k < 35; k++) begin
            y -= 4;
            push(1, 308, y, 0, -1);
            tick();
        end
        push(0, 0, 0, 0, -1);
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_reset_bullet_in", int'(bullet_in), 0);
        check("async_reset_bulletX", int'(bulletX), 0);
        check("async_reset_bulletY", int'(bulletY), 0);
        check("async_reset_score", int'(score_pulse), 0);
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        cyc(2);
        press();
        push(1, 308, 440, 0, -1);
        tick();
        push(1, 308, 436, 0, -1);
        tick();
        push(1, 308, 432, 0, -1);
        tick();

        // game_active drop mid-flight
        push(0, 308, 432, 0, -1);
        game_active = 1'b0;
        cyc(1);
        check("inactive_bullet_in", int'(bullet_in), 0);
        check("inactive_score", int'(score_pulse), 0);
        hit = 1'b1;
        cyc(2);
        hit = 1'b0;
        tick();
        game_active = 1'b1;
        cyc(2);
        tick();
        press();
        push(1, 308, 440, 0, -1);
        tick();
        push(1, 308, 436, 0, -1);
        tick();

        cyc(20);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_bullet_ctrl.md
Name: player_bullet_ctrl

Overview:
Owns the single player bullet, one frame at a time. It launches a bullet from the player's position on a fire request and advances it upward once per video frame. It retires the bullet when it passes the top of the screen or when a hit is reported. Sits directly upstream of color_mapper: it drives bullet_in/bulletX/bulletY and consumes color_mapper's hit output.

Parameters:
SPEED, 4, pixels the bullet rises per frame tick
START_Y, 440, bulletY loaded at launch (top edge of player sprite)
TOP_Y, 0, topmost legal bulletY; bullet retires once it cannot move SPEED further
X_OFS, 8, added to playerX at launch (sprite centre column)
COOLDOWN_FRAMES, 8, frame ticks between retire and re-arm; legal range 1..255

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous, active-low reset
frame_clk  input  1  VGA vsync, asynchronous to Clk; rising edge = new frame
game_active  input  1  high while in-game; low forces IDLE
fire  input  1  fire key level, synchronous to Clk
playerX  input  10  player sprite left X
hit  input  1  from color_mapper; bullet pixel overlapped an enemy
bullet_in  output  1  bullet visible/active
bulletX  output  10  bullet column
bulletY  output  10  bullet top row
score_pulse  output  1  one-Clk pulse when a hit retires the bullet

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE, bullet_in=0, bulletX=0, bulletY=0, score_pulse=0; all latches and counters cleared. Reset mid-flight removes the bullet immediately.
- frame_tick: frame_clk passes a 2-flop synchroniser, then rising-edge detect. Tick is a 1-Clk pulse 3 Clk edges after the frame_clk rise. All position updates occur only on tick cycles.
- fire_edge: fire high while fire was low on the previous Clk cycle. A held key never auto-repeats.
- States: IDLE, PENDING, FLYING, COOLDOWN.
- IDLE: bullet_in=0. fire_edge moves the block to PENDING.
- PENDING: bullet_in=0. Fire edges are ignored. On tick: bulletX=playerX+X_OFS (truncated to 10 bits, captured once and held constant in flight), bulletY=START_Y, bullet_in=1, move to FLYING. The launch happens only on a tick, so the bullet never appears mid-frame.
- FLYING: bullet_in=1.
  - Any cycle with hit=1 sets hit_latched. Further hits that frame are absorbed.
  - Priority on tick: hit_latched wins. Set bullet_in=0, pulse score_pulse for exactly one cycle, go to COOLDOWN.
  - Otherwise, if bulletY < TOP_Y+SPEED: set bullet_in=0 and go to COOLDOWN with no score (miss).
  - Otherwise bulletY -= SPEED. No underflow is possible.
- hit is ignored outside FLYING. hit_latched clears on entering COOLDOWN.
- COOLDOWN: bullet_in=0. The cooldown counter is loaded with COOLDOWN_FRAMES on entry and decrements each tick. At 0 the block returns to IDLE. Fire edges are discarded, so the player must press again after re-arm.
- A hit coinciding with a tick: it is latched that cycle and takes effect on the next tick. A hit asserted on the tick cycle counts for the new frame.
- game_active low in any state: next cycle state=IDLE, bullet_in=0, hit_latched=0, counter=0, score_pulse=0.
- bulletX and bulletY hold their last values when bullet_in=0. color_mapper gates on bullet_in.
- All outputs are registered. There is no combinational path from hit to any output.

Decomposition:
- Package space_invaders_pkg:
  - bullet_state_t enum {IDLE, PENDING, FLYING, COOLDOWN}
  - SCREEN_W=640, SCREEN_H=480
  - COORD_W=10
  - default SPEED, START_Y, X_OFS constants shared with color_mapper/enemy logic
- Sub-module frame_tick_sync: 2-flop synchroniser plus rising-edge detector with Clk/Reset_n. Produces the 1-cycle frame_tick. It is reused by the player and enemy movement blocks.

Test Plan:
- Launch (defaults), playerX=100, fire pulse, then 1 frame tick: bullet_in=1, bulletX=108, bulletY=440. After 10 more ticks bulletY=400 and bulletX stays 108 even if playerX changes to 200.
- Miss: after launch, run 110 ticks to reach bulletY=0. The 111th tick sets bullet_in=0 and score_pulse never asserts.
- Hit: at bulletY=400, pulse hit for 3 cycles mid-frame. bullet_in stays 1 until the next tick, then drops to 0 and score_pulse=1 for exactly 1 cycle.
- Cooldown and fire edges:
  - After retire, fire edges on ticks 1..7 are ignored. After tick 8 the block is in IDLE.
  - A fire held continuously through cooldown does not launch.
  - Release, then press: the bullet launches on the following tick.
- Reset_n low for 1 cycle mid-flight at bulletY=300: all outputs are 0 immediately (asynchronously). A subsequent fire_edge launches normally.
- game_active low during FLYING: bullet_in=0 next cycle with no score_pulse. A hit asserted while game_active is low has no effect.
